// File: rtl/tlp_xcvr_pkg.sv
// Shared types for the PCIe register/DMA transceiver: TLP header helpers,
// the Action entry passed from the RX parser to the transmit FSM.
package tlp_xcvr_pkg;

  localparam int CHAN_W = 14;

  localparam logic [7:0] TLP_MRD32 = 8'h00;
  localparam logic [7:0] TLP_MWR32 = 8'h40;

  typedef enum logic [1:0] {
    ACT_NONE  = 2'd0,
    ACT_READ  = 2'd1,
    ACT_WRITE = 2'd2,
    ACT_ERROR = 2'd3
  } ActionKind;

  typedef enum logic [2:0] {
    ERR_NONE        = 3'd0,
    ERR_UNSUPPORTED = 3'd1,
    ERR_BAD_LENGTH  = 3'd2,
    ERR_BAD_BE      = 3'd3,
    ERR_MALFORMED   = 3'd4
  } ErrorCode;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HDR1 = 2'd1,
    S_DATA = 2'd2,
    S_DROP = 2'd3
  } RecvState;

  // All payload views are padded to the same 46 bits so they overlay in a packed union.
  typedef struct packed {
    logic [7:0]        pad;
    logic [15:0]       reqID;
    logic [7:0]        tag;
    logic [CHAN_W-1:0] chan;
  } RegRead;

  typedef struct packed {
    logic [CHAN_W-1:0] chan;
    logic [31:0]       data;
  } RegWrite;

  typedef struct packed {
    logic [42:0] pad;
    ErrorCode    code;
  } ErrorView;

  typedef union packed {
    RegRead   rd;
    RegWrite  wr;
    ErrorView err;
  } ActionPayload;

  typedef struct packed {
    ActionKind    kind;
    ActionPayload p;
  } Action;

  function automatic logic [15:0] getReqID(input logic [63:0] qw);
    return qw[63:48];
  endfunction

  function automatic logic [7:0] getTag(input logic [63:0] qw);
    return qw[47:40];
  endfunction

  function automatic logic [9:0] getLength(input logic [63:0] qw);
    return qw[9:0];
  endfunction

  function automatic logic [7:0] getFmtType(input logic [63:0] qw);
    return qw[31:24];
  endfunction

  function automatic logic [3:0] getFirstBE(input logic [63:0] qw);
    return qw[35:32];
  endfunction

  function automatic logic [3:0] getLastBE(input logic [63:0] qw);
    return qw[39:36];
  endfunction

endpackage

// File: rtl/tlp_recv_if.sv
// RX Avalon-ST beat stream plus the decoded-action handshake of tlp_recv.
interface tlp_recv_if;
  import tlp_xcvr_pkg::*;

  logic [63:0] rxData_in;
  logic        rxValid_in;
  logic        rxReady_out;
  logic        rxSOP_in;
  logic        rxEOP_in;
  Action       actData_out;
  logic        actValid_out;
  logic        actReady_in;

  modport master (
    output rxData_in, rxValid_in, rxSOP_in, rxEOP_in, actReady_in,
    input  rxReady_out, actData_out, actValid_out
  );

  modport slave (
    input  rxData_in, rxValid_in, rxSOP_in, rxEOP_in, actReady_in,
    output rxReady_out, actData_out, actValid_out
  );

endinterface

// File: rtl/tlp_recv.sv
// RX-side TLP parser: turns 32-bit MRd/MWr TLPs to the register BAR into
// Action entries, reporting bad TLPs as one ACT_ERROR each.
module tlp_recv
  import tlp_xcvr_pkg::*;
#(
  parameter bit ERR_ON_BAD_BE    = 1'b1,
  parameter int ADDR_DECODE_BITS = 16
) (
  input  logic           pcieClk_in,
  input  logic           pcieRst_n_in,
  tlp_recv_if.slave      bus,
  output logic [31:0]    errCount_out
);

  RecvState          state, nextState;
  logic [63:0]       hdrQ;
  logic [CHAN_W-1:0] chanQ;
  Action             actQ, emitAct;
  logic              actValidQ;
  logic              emit, latchHdr, latchChan;
  logic              accept;
  logic [31:0]       addr;
  logic              beOk;

  function automatic logic [CHAN_W-1:0] chanOf(input logic [31:0] a);
    logic [31:0] m;
    m = (a >> 2) & ((32'h1 << (ADDR_DECODE_BITS - 2)) - 32'h1);
    return m[CHAN_W-1:0];
  endfunction

  function automatic Action mkError(input ErrorCode code);
    Action a;
    a = '0;
    a.kind = ACT_ERROR;
    a.p.err.code = code;
    return a;
  endfunction

  assign bus.rxReady_out  = pcieRst_n_in && !actValidQ;
  assign bus.actValid_out = actValidQ;
  assign bus.actData_out  = actQ;
  assign accept = bus.rxValid_in && bus.rxReady_out;
  assign addr   = bus.rxData_in[31:0];
  assign beOk   = !ERR_ON_BAD_BE ||
                  (getFirstBE(hdrQ) == 4'hF && getLastBE(hdrQ) == 4'h0);

  always_comb begin
    nextState = state;
    emit      = 1'b0;
    emitAct   = '0;
    latchHdr  = 1'b0;
    latchChan = 1'b0;
    if (accept) begin
      unique case (state)
        S_IDLE: begin
          if (bus.rxSOP_in && bus.rxEOP_in) begin
            emit    = 1'b1;
            emitAct = mkError(ERR_MALFORMED);
          end else if (bus.rxSOP_in) begin
            latchHdr  = 1'b1;
            nextState = S_HDR1;
          end
        end
        S_HDR1: begin
          nextState = bus.rxEOP_in ? S_IDLE : S_DROP;
          emit      = 1'b1;
          if (getFmtType(hdrQ) != TLP_MRD32 && getFmtType(hdrQ) != TLP_MWR32) begin
            emitAct = mkError(ERR_UNSUPPORTED);
          end else if (getLength(hdrQ) != 10'd1) begin
            emitAct = mkError(ERR_BAD_LENGTH);
          end else if (!beOk) begin
            emitAct = mkError(ERR_BAD_BE);
          end else if (getFmtType(hdrQ) == TLP_MRD32) begin
            if (bus.rxEOP_in) begin
              emitAct.kind       = ACT_READ;
              emitAct.p.rd.reqID = getReqID(hdrQ);
              emitAct.p.rd.tag   = getTag(hdrQ);
              emitAct.p.rd.chan  = chanOf(addr);
            end else begin
              emitAct = mkError(ERR_MALFORMED);
            end
          end else if (addr[2]) begin
            emitAct.kind      = ACT_WRITE;
            emitAct.p.wr.chan = chanOf(addr);
            emitAct.p.wr.data = bus.rxData_in[63:32];
            nextState         = S_IDLE;
          end else if (bus.rxEOP_in) begin
            emitAct = mkError(ERR_MALFORMED);
          end else begin
            emit      = 1'b0;
            latchChan = 1'b1;
            nextState = S_DATA;
          end
        end
        S_DATA: begin
          emit = 1'b1;
          // An intruding SOP is reported once, then parsed as the start of a fresh TLP.
          if (bus.rxSOP_in) begin
            emitAct = mkError(ERR_MALFORMED);
            if (bus.rxEOP_in) begin
              nextState = S_IDLE;
            end else begin
              latchHdr  = 1'b1;
              nextState = S_HDR1;
            end
          end else if (bus.rxEOP_in) begin
            emitAct.kind      = ACT_WRITE;
            emitAct.p.wr.chan = chanQ;
            emitAct.p.wr.data = bus.rxData_in[31:0];
            nextState         = S_IDLE;
          end else begin
            emitAct   = mkError(ERR_MALFORMED);
            nextState = S_DROP;
          end
        end
        S_DROP: begin
          if (bus.rxSOP_in && !bus.rxEOP_in) begin
            latchHdr  = 1'b1;
            nextState = S_HDR1;
          end else if (bus.rxEOP_in) begin
            nextState = S_IDLE;
          end
        end
        default: nextState = S_IDLE;
      endcase
    end
  end

  // State, latched header and the single-entry action register; no beat is
  // accepted while an action is pending, so emit never collides with a pending one.
  always_ff @(posedge pcieClk_in or negedge pcieRst_n_in) begin
    if (!pcieRst_n_in) begin
      state        <= S_IDLE;
      hdrQ         <= '0;
      chanQ        <= '0;
      actQ         <= '0;
      actValidQ    <= 1'b0;
      errCount_out <= '0;
    end else begin
      state <= nextState;
      if (latchHdr) begin
        hdrQ <= bus.rxData_in;
      end
      if (latchChan) begin
        chanQ <= chanOf(addr);
      end
      if (emit) begin
        actQ      <= emitAct;
        actValidQ <= 1'b1;
      end else if (actValidQ && bus.actReady_in) begin
        actValidQ <= 1'b0;
      end
      if (emit && emitAct.kind == ACT_ERROR && errCount_out != 32'hFFFF_FFFF) begin
        errCount_out <= errCount_out + 32'd1;
      end
    end
  end

endmodule
